// File: rtl/jpc_ifetch_if.sv
// Fetch-side bundle: PC handshake with jpc_pc, instruction-memory bus and
// the decode-facing instruction buffer.
interface jpc_ifetch_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    logic [ADDR_W-1:0]  pc_I;
    logic [ADDR_W-1:0]  next_pc_O;
    logic               pc_enable_O;
    logic               redirect_I;
    logic [ADDR_W-1:0]  redirect_pc_I;
    logic               imem_req_O;
    logic [ADDR_W-1:0]  imem_addr_O;
    logic               imem_gnt_I;
    logic               imem_rvalid_I;
    logic [INSTR_W-1:0] imem_rdata_I;
    logic               instr_valid_O;
    logic [INSTR_W-1:0] instr_O;
    logic [ADDR_W-1:0]  instr_pc_O;
    logic               instr_ready_I;

    // Fetch unit side
    modport master (
        input  pc_I, redirect_I, redirect_pc_I, imem_gnt_I, imem_rvalid_I,
               imem_rdata_I, instr_ready_I,
        output next_pc_O, pc_enable_O, imem_req_O, imem_addr_O,
               instr_valid_O, instr_O, instr_pc_O
    );

    // Environment side (jpc_pc, memory, decode)
    modport slave (
        output pc_I, redirect_I, redirect_pc_I, imem_gnt_I, imem_rvalid_I,
               imem_rdata_I, instr_ready_I,
        input  next_pc_O, pc_enable_O, imem_req_O, imem_addr_O,
               instr_valid_O, instr_O, instr_pc_O
    );
endinterface

// File: rtl/jpc_ifetch.sv
// Instruction fetch: one outstanding memory request, 1-entry decode buffer,
// next-PC control back into jpc_pc with redirect squashing.
module jpc_ifetch #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_INC  = 4
) (
    input logic          clk,
    input logic          rst,
    jpc_ifetch_if.master bus
);
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t             state;
    logic               drop;
    logic [ADDR_W-1:0]  pend_pc;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;

    logic               can_issue;
    logic               req;
    logic               grant;
    logic [ADDR_W-1:0]  pc_plus;

    // Request/PC control; request and enable are gated off while reset is held
    always_comb begin
        can_issue = !instr_valid || bus.instr_ready_I;
        req       = rst && (state == S_REQ) && can_issue;
        grant     = req && bus.imem_gnt_I;
        pc_plus   = bus.pc_I + INC;

        bus.imem_req_O  = req;
        bus.imem_addr_O = bus.pc_I;
        if (!rst) begin
            bus.pc_enable_O = 1'b0;
            bus.next_pc_O   = pc_plus;
        end else if (bus.redirect_I) begin
            bus.pc_enable_O = 1'b1;
            bus.next_pc_O   = bus.redirect_pc_I;
        end else begin
            bus.pc_enable_O = grant;
            bus.next_pc_O   = pc_plus;
        end
        bus.instr_valid_O = instr_valid;
        bus.instr_O       = instr;
        bus.instr_pc_O    = instr_pc;
    end

    // Fetch FSM and decode buffer; redirect clearing is applied last so it
    // overrides both a same-cycle load and the consume path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REQ;
            drop        <= 1'b0;
            pend_pc     <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            if (instr_valid && bus.instr_ready_I) begin
                instr_valid <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (grant) begin
                        pend_pc <= bus.pc_I;
                        drop    <= bus.redirect_I;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid_I) begin
                        if (!drop && !bus.redirect_I) begin
                            instr       <= bus.imem_rdata_I;
                            instr_pc    <= pend_pc;
                            instr_valid <= 1'b1;
                        end
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end else if (bus.redirect_I) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
            if (bus.redirect_I) begin
                instr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jpc_ifetch.sv
// Bench for jpc_ifetch: directed scenarios followed by random traffic, all
// checked against a transaction-level model (in-flight queue + buffer queue).
module tb_jpc_ifetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jpc_ifetch_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    jpc_ifetch #(.ADDR_W(32), .INSTR_W(32), .PC_INC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        bit          squashed;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    txn_t        inflight[$];
    ent_t        buf_q[$];
    logic [31:0] pc;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the settled
    // outputs against the model, then advance the model for the next rising edge.
    task automatic step(input bit rd, input logic [31:0] rpc, input bit g,
                        input bit rv, input logic [31:0] rdat, input bit rdy);
        bit          exp_req;
        bit          exp_en;
        logic [31:0] exp_next;
        txn_t        t;
        ent_t        e;
        @(negedge clk);
        bus.pc_I          = pc;
        bus.redirect_I    = rd;
        bus.redirect_pc_I = rpc;
        bus.imem_gnt_I    = g;
        bus.imem_rvalid_I = rv;
        bus.imem_rdata_I  = rdat;
        bus.instr_ready_I = rdy;
        #1;
        exp_req  = (inflight.size() == 0) && (buf_q.size() == 0 || rdy);
        exp_en   = rd || (exp_req && g);
        exp_next = rd ? rpc : pc + 32'd4;
        chk("imem_req", 32'(bus.imem_req_O), 32'(exp_req));
        if (exp_req) chk("imem_addr", bus.imem_addr_O, pc);
        chk("pc_enable", 32'(bus.pc_enable_O), 32'(exp_en));
        chk("next_pc", bus.next_pc_O, exp_next);
        chk("instr_valid", 32'(bus.instr_valid_O), 32'(buf_q.size() != 0));
        if (buf_q.size() != 0) begin
            chk("instr", bus.instr_O, buf_q[0].data);
            chk("instr_pc", bus.instr_pc_O, buf_q[0].pc);
        end
        // model update for the coming edge
        if (buf_q.size() != 0 && rdy) void'(buf_q.pop_front());
        if (inflight.size() != 0 && rv) begin
            t = inflight.pop_front();
            if (!t.squashed) begin
                e.data = rdat;
                e.pc   = t.addr;
                buf_q.push_back(e);
            end
        end
        if (rd) begin
            buf_q.delete();
            foreach (inflight[i]) inflight[i].squashed = 1'b1;
        end
        if (exp_req && g) begin
            t.addr     = pc;
            t.squashed = rd;
            inflight.push_back(t);
        end
        if (exp_en) pc = exp_next;
    endtask

    initial begin
        bus.pc_I          = '0;
        bus.redirect_I    = 1'b1;
        bus.redirect_pc_I = 32'h40;
        bus.imem_gnt_I    = 1'b1;
        bus.imem_rvalid_I = 1'b0;
        bus.imem_rdata_I  = '0;
        bus.instr_ready_I = 1'b1;
        pc = '0;

        // reset state, with redirect/ready asserted to show the forcing
        repeat (3) @(posedge clk);
        #2;
        chk("rst_instr_valid", 32'(bus.instr_valid_O), 32'h0);
        chk("rst_instr", bus.instr_O, 32'h0);
        chk("rst_instr_pc", bus.instr_pc_O, 32'h0);
        chk("rst_imem_req", 32'(bus.imem_req_O), 32'h0);
        chk("rst_pc_enable", 32'(bus.pc_enable_O), 32'h0);
        rst = 1'b1;

        // 1: first fetch at pc 0, gnt at once, data next cycle
        step(0, 0, 1, 0, 0, 0);
        chk("t1_next_pc", bus.next_pc_O, 32'h4);
        chk("t1_pc_enable", 32'(bus.pc_enable_O), 32'h1);
        step(0, 0, 0, 1, 32'h13, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("t1_instr", bus.instr_O, 32'h13);
        chk("t1_instr_pc", bus.instr_pc_O, 32'h0);

        // 2: full buffer blocks requests until decode is ready
        step(0, 0, 0, 0, 0, 0);
        chk("t2_hold_instr", bus.instr_O, 32'h13);
        step(0, 0, 0, 0, 0, 1);
        chk("t2_req_on_drain", 32'(bus.imem_req_O), 32'h1);
        step(0, 0, 0, 0, 0, 0);
        chk("t2_cleared", 32'(bus.instr_valid_O), 32'h0);

        // 3: redirect while waiting on pc 0x8, late response dropped
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 32'h17, 1);
        step(0, 0, 1, 0, 0, 1);
        chk("t3_wait_pc", bus.imem_addr_O, 32'h8);
        step(1, 32'h100, 0, 0, 0, 1);
        chk("t3_next_pc", bus.next_pc_O, 32'h100);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 32'hDEADBEEF, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t3_no_valid", 32'(bus.instr_valid_O), 32'h0);
        chk("t3_new_addr", bus.imem_addr_O, 32'h100);

        // 4: redirect coincident with grant
        step(1, 32'h200, 1, 0, 0, 1);
        chk("t4_next_pc", bus.next_pc_O, 32'h200);
        step(0, 0, 0, 1, 32'hCAFE0001, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t4_no_valid", 32'(bus.instr_valid_O), 32'h0);
        chk("t4_new_addr", bus.imem_addr_O, 32'h200);

        // 5: wrap-around of the sequential PC
        step(1, 32'hFFFFFFFC, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        chk("t5_next_pc", bus.next_pc_O, 32'h0);
        step(0, 0, 0, 1, 32'h55, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("t5_instr_pc", bus.instr_pc_O, 32'hFFFFFFFC);

        // 6: async reset mid-WAIT, stale response ignored after release
        step(0, 0, 1, 0, 0, 1);
        @(posedge clk);
        #3;
        bus.redirect_I    = 1'b1;
        bus.instr_ready_I = 1'b1;
        rst = 1'b0;
        #1;
        chk("t6_instr_valid", 32'(bus.instr_valid_O), 32'h0);
        chk("t6_imem_req", 32'(bus.imem_req_O), 32'h0);
        chk("t6_pc_enable", 32'(bus.pc_enable_O), 32'h0);
        inflight.delete();
        buf_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        step(0, 0, 0, 1, 32'hBAD0BAD0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t6_stale_ignored", 32'(bus.instr_valid_O), 32'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bit rd, g, rv, rdy;
            rd  = ($urandom_range(7) == 0);
            g   = ($urandom_range(2) != 0);
            rdy = ($urandom_range(3) != 0);
            rv  = (inflight.size() != 0) ? ($urandom_range(1) == 1)
                                         : ($urandom_range(7) == 0);
            step(rd, $urandom & 32'hFFFFFFFC, g, rv, $urandom, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
